// File: rtl/router_pkg.sv
// Shared types and constants for the router input-channel control FSM.
package router_pkg;

  localparam int unsigned NUM_PORTS_DEF    = 3;
  localparam int unsigned ADDR_W_DEF       = 2;
  localparam int unsigned WAIT_TIMEOUT_DEF = 32;

  // Header address that never maps to a port in the default 3-port build.
  localparam logic [1:0] ADDR_INVALID = 2'b11;

  typedef enum logic [2:0] {
    StDecodeAddress,
    StLoadFirstData,
    StLoadData,
    StFifoFull,
    StLoadAfterFull,
    StLoadParity,
    StCheckParityError,
    StWaitTillEmpty
  } state_e;

  // A header is accepted only for an address that names an existing port.
  function automatic logic hdr_valid(input logic        pkt_valid,
                                     input int unsigned addr,
                                     input int unsigned num_ports);
    return pkt_valid && (addr < num_ports);
  endfunction

endpackage

// File: rtl/router_fsm_if.sv
// Control/status bundle between the packet source, register block, FIFOs and the FSM.
// master: environment side driving the FSM inputs. slave: the FSM itself.
interface router_fsm_if #(
  parameter int unsigned NUM_PORTS = 3,
  parameter int unsigned ADDR_W    = 2
);

  logic                 pkt_valid;
  logic [ADDR_W-1:0]    data_in;
  logic                 fifo_full;
  logic [NUM_PORTS-1:0] fifo_empty;
  logic [NUM_PORTS-1:0] soft_reset;
  logic                 parity_done;
  logic                 low_pkt_valid;

  logic                 detect_add;
  logic                 lfd_state;
  logic                 ld_state;
  logic                 laf_state;
  logic                 full_state;
  logic                 rst_int_reg;
  logic                 write_enb_reg;
  logic                 busy;
  logic                 drop_pkt;

  modport master (
    output pkt_valid, data_in, fifo_full, fifo_empty, soft_reset, parity_done, low_pkt_valid,
    input  detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
           write_enb_reg, busy, drop_pkt
  );

  modport slave (
    input  pkt_valid, data_in, fifo_full, fifo_empty, soft_reset, parity_done, low_pkt_valid,
    output detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
           write_enb_reg, busy, drop_pkt
  );

endinterface

// File: rtl/router_wait_timer.sv
// Cycle counter for the WAIT_TILL_EMPTY state: clear has priority over enable, expire_o
// flags the final allowed cycle (count == Limit-1).
module router_wait_timer #(
  parameter int unsigned Limit = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int unsigned CntW = (Limit > 1) ? $clog2(Limit) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;

  // Next count: clear, advance, or hold.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = (cnt_q == CntW'(Limit - 1));

endmodule

// File: rtl/router_fsm.sv
// Router input-channel control FSM. Decodes the header address, sequences the register
// block through header/payload/full-stall/parity phases and gates FIFO writes.
// Optional feature macro: ROUTER_FSM_WAIT_TIMEOUT_EN adds a WAIT_TILL_EMPTY timeout that
// abandons the packet and pulses drop_pkt; without it WAIT_TILL_EMPTY holds indefinitely.
module router_fsm
  import router_pkg::*;
#(
  parameter int unsigned NUM_PORTS    = NUM_PORTS_DEF,
  parameter int unsigned ADDR_W       = ADDR_W_DEF,
  parameter int unsigned WAIT_TIMEOUT = WAIT_TIMEOUT_DEF
) (
  input logic         clk,
  input logic         rst,
  router_fsm_if.slave bus
);

  // Per-port vectors widened to the full address space so any addr indexes safely.
  localparam int unsigned NumSel = 2 ** ADDR_W;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  logic [NumSel-1:0] empty_ext, srst_ext;
  logic              hdr_ok, empty_hdr, empty_sel, srst_sel;
  logic              timeout_hit;

  // Zero-extend per-port flags so unused addresses read as not-empty / no soft reset.
  always_comb begin
    empty_ext                = '0;
    srst_ext                 = '0;
    empty_ext[NUM_PORTS-1:0] = bus.fifo_empty;
    srst_ext[NUM_PORTS-1:0]  = bus.soft_reset;
  end

  assign hdr_ok    = hdr_valid(bus.pkt_valid, 32'(bus.data_in), NUM_PORTS);
  assign empty_hdr = empty_ext[bus.data_in];
  assign empty_sel = empty_ext[addr_q];
  assign srst_sel  = srst_ext[addr_q];

`ifdef ROUTER_FSM_WAIT_TIMEOUT_EN
  logic expire;
  logic drop_q, drop_d;

  router_wait_timer #(
    .Limit (WAIT_TIMEOUT)
  ) u_wait_timer (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (state_q != StWaitTillEmpty),
    .en_i     (state_q == StWaitTillEmpty),
    .expire_o (expire)
  );

  // An arriving empty flag in the expiry cycle still wins over the timeout.
  assign timeout_hit = (state_q == StWaitTillEmpty) && expire && !empty_sel;

  // drop_pkt pulses only when the timeout itself abandons the packet.
  always_comb begin
    drop_d = timeout_hit && !srst_sel;
  end

  // Registered drop pulse.
  always_ff @(posedge clk) begin
    if (!rst) begin
      drop_q <= 1'b0;
    end else begin
      drop_q <= drop_d;
    end
  end

  assign bus.drop_pkt = drop_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^WAIT_TIMEOUT;
  assign timeout_hit    = 1'b0;
  assign bus.drop_pkt   = 1'b0;
`endif

  // Next-state and address capture: soft reset > timeout > normal transitions.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;

    if (state_q == StDecodeAddress && bus.pkt_valid) begin
      addr_d = bus.data_in;
    end

    if (state_q != StDecodeAddress && srst_sel) begin
      state_d = StDecodeAddress;
    end else if (timeout_hit) begin
      state_d = StDecodeAddress;
    end else begin
      unique case (state_q)
        StDecodeAddress: begin
          if (hdr_ok) begin
            state_d = empty_hdr ? StLoadFirstData : StWaitTillEmpty;
          end
        end
        StLoadFirstData: state_d = StLoadData;
        StLoadData: begin
          if (bus.fifo_full) begin
            state_d = StFifoFull;
          end else if (!bus.pkt_valid) begin
            state_d = StLoadParity;
          end
        end
        StFifoFull: begin
          if (!bus.fifo_full) begin
            state_d = StLoadAfterFull;
          end
        end
        StLoadAfterFull: begin
          if (bus.parity_done) begin
            state_d = StDecodeAddress;
          end else if (bus.low_pkt_valid) begin
            state_d = StLoadParity;
          end else begin
            state_d = StLoadData;
          end
        end
        StLoadParity: state_d = StCheckParityError;
        StCheckParityError: begin
          state_d = bus.fifo_full ? StFifoFull : StDecodeAddress;
        end
        StWaitTillEmpty: begin
          if (empty_sel) begin
            state_d = StLoadFirstData;
          end
        end
        default: state_d = StDecodeAddress;
      endcase
    end
  end

  // State and captured address, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StDecodeAddress;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  // Moore outputs: pure decodes of the registered state.
  assign bus.detect_add    = (state_q == StDecodeAddress);
  assign bus.lfd_state     = (state_q == StLoadFirstData);
  assign bus.ld_state      = (state_q == StLoadData);
  assign bus.laf_state     = (state_q == StLoadAfterFull);
  assign bus.full_state    = (state_q == StFifoFull);
  assign bus.rst_int_reg   = (state_q == StCheckParityError);
  assign bus.write_enb_reg = (state_q == StLoadData) || (state_q == StLoadParity) ||
                             (state_q == StLoadAfterFull);
  assign bus.busy          = (state_q != StDecodeAddress) && (state_q != StLoadData);

endmodule
